// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: default widths, ALU control
// codes, FSM state encoding and the opcode legality helper.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b1011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_AND, ALU_SUB, ALU_OR,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant history is held by the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention goes to the port that did not win last time.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters (round-robin, 2-cycle latency).
// Optional opcode legality check enabled by defining ALU_SHARE_ARB_OPCHK_EN.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              can_accept;
    logic              accept;
    logic              sel1;
    logic              latch_alu;
    logic              rsp_fire;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

`ifdef ALU_SHARE_ARB_OPCHK_EN
    logic              err_q, err_d;
    logic              rsp_err_q, rsp_err_d;
    logic              sel_legal;
`endif

    rr_arb2 u_arb (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Accept window: IDLE and RESP, never while reset is asserted.
    always_comb begin
        can_accept = !reset && (state_q == ST_IDLE || state_q == ST_RESP);
        arb_req    = can_accept ? {req1_valid, req0_valid} : 2'b00;
        accept     = |grant;
        sel1       = grant[1];
        sel_ctrl   = sel1 ? req1_ctrl : req0_ctrl;
        sel_a      = sel1 ? req1_a    : req0_a;
        sel_b      = sel1 ? req1_b    : req0_b;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        sel_legal  = alu_op_legal(ALU_CTRL_W'(sel_ctrl));
        latch_alu  = accept && sel_legal;
`else
        latch_alu  = accept;
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        err_d        = err_q;
        rsp_err_d    = rsp_err_q;
`endif

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d      = ST_ISSUE;
                    owner_d      = sel1;
                    last_grant_d = sel1;
`ifdef ALU_SHARE_ARB_OPCHK_EN
                    err_d        = !sel_legal;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
`ifdef ALU_SHARE_ARB_OPCHK_EN
                // Illegal ops never reached the ALU; report a cleared result.
                if (err_q) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b0;
                end else begin
                    rsp_result_d = alu_out;
                    rsp_zero_d   = alu_zero;
                end
                rsp_err_d = err_q;
`else
                rsp_result_d = alu_out;
                rsp_zero_d   = alu_zero;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch_alu) begin
            alu_ctrl_d = sel_ctrl;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_SHARE_ARB_OPCHK_EN
            err_q        <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_SHARE_ARB_OPCHK_EN
            err_q        <= err_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign rsp_fire   = (state_q == ST_RESP) && !reset;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_fire && !owner_q;
    assign rsp1_valid = rsp_fire && owner_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
`ifdef ALU_SHARE_ARB_OPCHK_EN
    assign rsp_err    = rsp_fire && rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vectors, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        rsp0_valid, rsp1_valid, rsp_zero, rsp_err;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    // Environment ALU: shifts move b by a[4:0]; unknown codes produce 0.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            4'b1000: return a + b;
            4'b1100: return a & b;
            4'b1001: return a - b;
            4'b0100: return a | b;
            4'b1011: return b << a[4:0];
            4'b1010: return b >> a[4:0];
            4'b0010: return $signed(b) >>> a[4:0];
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = ref_alu(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_out == 32'd0);
    end

    typedef struct {
        int          port;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
        end
    endtask

    task automatic run_single(input vec_t v);
        tick();
        set_req(v.port, 1'b1, v.ctrl, v.a, v.b);
        @(negedge clk);
        check1("single_ready", (v.port == 0) ? req0_ready : req1_ready, 1'b1);
        check1("single_other_ready", (v.port == 0) ? req1_ready : req0_ready, 1'b0);
        tick();
        set_req(v.port, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check1("single_no_rsp_T1", rsp0_valid | rsp1_valid, 1'b0);
        check("single_alu_ctrl", 32'(alu_ctrl), 32'(v.ctrl));
        check("single_alu_a", alu_a, v.a);
        check("single_alu_b", alu_b, v.b);
        tick();
        @(negedge clk);
        check1("single_rsp0", rsp0_valid, v.port == 0);
        check1("single_rsp1", rsp1_valid, v.port == 1);
        check("single_result", rsp_result, v.res);
        check1("single_zero", rsp_zero, v.zero);
        check1("single_err", rsp_err, 1'b0);
        tick();
        @(negedge clk);
        check1("single_rsp_done", rsp0_valid | rsp1_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        exp_t        exp_q[$];
        logic [3:0]  codes[8];
        logic        pv[2];
        logic        acc[2];
        logic [3:0]  pc[2];
        logic [31:0] pa[2];
        logic [31:0] pb[2];
        int          m_last;
        logic        m_prev_acc;
        int          exp_g;
        logic        e0, e1;

        vecs[0] = '{0, 4'b1000, 32'h00425020, 32'h00425020, 32'h0084A040, 1'b0};
        vecs[1] = '{1, 4'b1001, 32'h00425020, 32'h00425020, 32'h00000000, 1'b1};
        vecs[2] = '{0, 4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
        vecs[3] = '{1, 4'b0100, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[4] = '{0, 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vecs[5] = '{1, 4'b1010, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
        vecs[6] = '{0, 4'b0010, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
        vecs[7] = '{1, 4'b1011, 32'h00000001, 32'h0000000E, 32'h0000001C, 1'b0};
        codes   = '{4'b1000, 4'b1100, 4'b1001, 4'b0100, 4'b1011, 4'b1010, 4'b0010, 4'b0111};

        reset = 1'b1;
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 4'b1000, 32'h1, 32'h1);
        set_req(1, 1'b1, 4'b1000, 32'h2, 32'h2);
        @(negedge clk);
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_ready1", req1_ready, 1'b0);
        check1("rst_rsp", rsp0_valid | rsp1_valid, 1'b0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_result", rsp_result, 32'h0);
        check1("rst_zero", rsp_zero, 1'b0);
        check1("rst_err", rsp_err, 1'b0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Contention right after reset: port 0 first, port 1 in port 0's RESP cycle.
        tick();
        set_req(0, 1'b1, 4'b0100, 32'hFFFFFFE0, 32'h00425020);
        set_req(1, 1'b1, 4'b1011, 32'h00000001, 32'h0000000E);
        @(negedge clk);
        check1("cont_ready0", req0_ready, 1'b1);
        check1("cont_ready1", req1_ready, 1'b0);
        tick();
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check1("cont_issue_ready1", req1_ready, 1'b0);
        check("cont_alu_ctrl0", 32'(alu_ctrl), 32'h4);
        tick();
        @(negedge clk);
        check1("cont_rsp0", rsp0_valid, 1'b1);
        check1("cont_rsp1_idle", rsp1_valid, 1'b0);
        check("cont_result0", rsp_result, 32'hFFFFFFE0);
        check1("cont_zero0", rsp_zero, 1'b0);
        check1("cont_ready1_in_resp", req1_ready, 1'b1);
        tick();
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check1("cont_gap", rsp0_valid | rsp1_valid, 1'b0);
        check("cont_alu_ctrl1", 32'(alu_ctrl), 32'hB);
        tick();
        @(negedge clk);
        check1("cont_rsp1", rsp1_valid, 1'b1);
        check("cont_result1", rsp_result, 32'h0000001C);
        tick();
        set_req(0, 1'b1, 4'b1000, 32'd2, 32'd3);
        set_req(1, 1'b1, 4'b1000, 32'd4, 32'd4);
        @(negedge clk);
        check1("cont2_ready0", req0_ready, 1'b1);
        check1("cont2_ready1", req1_ready, 1'b0);
        tick();
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        @(negedge clk);
        check1("cont2_rsp0", rsp0_valid, 1'b1);
        check("cont2_result", rsp_result, 32'd5);
        tick();

        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // Port 0 streams four adds; one accept every two cycles.
        for (int c = 0; c < 10; c++) begin
            int k;
            k = c / 2;
            tick();
            if (k < 4) set_req(0, 1'b1, 4'b1000, 32'(k) * 32'h11111111, 32'h1);
            else       set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            check1("b2b_ready", req0_ready, (c % 2 == 0) && (k < 4));
            check1("b2b_rsp", rsp0_valid, (c >= 2) && (c % 2 == 0) && (c <= 8));
            if ((c >= 2) && (c % 2 == 0) && (c <= 8))
                check("b2b_result", rsp_result, 32'((c - 2) / 2) * 32'h11111111 + 32'h1);
        end

        // Reset during ISSUE: the op is dropped and history returns to reset.
        tick();
        set_req(0, 1'b1, 4'b1000, 32'd7, 32'd8);
        @(negedge clk);
        check1("rstiss_ready0", req0_ready, 1'b1);
        tick();
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check1("rstiss_no_rsp_a", rsp0_valid | rsp1_valid, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check1("rstiss_no_rsp_b", rsp0_valid | rsp1_valid, 1'b0);
        check("rstiss_alu_ctrl", 32'(alu_ctrl), 32'h0);
        check("rstiss_alu_a", alu_a, 32'h0);
        check("rstiss_alu_b", alu_b, 32'h0);
        check("rstiss_result", rsp_result, 32'h0);
        tick();
        @(negedge clk);
        check1("rstiss_no_rsp_c", rsp0_valid | rsp1_valid, 1'b0);
        tick();
        set_req(0, 1'b1, 4'b1000, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'b1000, 32'd2, 32'd2);
        @(negedge clk);
        check1("rstiss_ready0", req0_ready, 1'b1);
        check1("rstiss_ready1", req1_ready, 1'b0);
        tick();
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();

        // Illegal control code 1111 after a known legal op.
        run_single('{0, 4'b1000, 32'd1, 32'd2, 32'd3, 1'b0});
        tick();
        set_req(1, 1'b1, 4'b1111, 32'd5, 32'd6);
        @(negedge clk);
        check1("ill_ready1", req1_ready, 1'b1);
        tick();
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
`ifdef ALU_SHARE_ARB_OPCHK_EN
        check("ill_alu_ctrl", 32'(alu_ctrl), 32'h8);
        check("ill_alu_a", alu_a, 32'd1);
`else
        check("ill_alu_ctrl", 32'(alu_ctrl), 32'hF);
        check("ill_alu_a", alu_a, 32'd5);
`endif
        tick();
        @(negedge clk);
        check1("ill_rsp1", rsp1_valid, 1'b1);
        check("ill_result", rsp_result, 32'h0);
`ifdef ALU_SHARE_ARB_OPCHK_EN
        check1("ill_err", rsp_err, 1'b1);
        check1("ill_zero", rsp_zero, 1'b0);
`else
        check1("ill_err", rsp_err, 1'b0);
        check1("ill_zero", rsp_zero, 1'b1);
`endif
        tick();
        @(negedge clk);
        check1("ill_err_clear", rsp_err, 1'b0);

        // Randomized traffic against a transaction-level model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last     = 1;
        m_prev_acc = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; acc[p] = 1'b0; pc[p] = 4'h0; pa[p] = 32'h0; pb[p] = 32'h0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) pv[p] = 1'b0;
                if (!pv[p] && ($urandom_range(0, 2) != 0)) begin
                    pv[p] = 1'b1;
                    pc[p] = codes[$urandom_range(0, 7)];
                    pa[p] = $urandom;
                    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
                end
                set_req(p, pv[p], pc[p], pa[p], pb[p]);
            end
            @(negedge clk);
            exp_g = -1;
            if (!m_prev_acc) begin
                if (pv[0] && pv[1]) exp_g = 1 - m_last;
                else if (pv[0])     exp_g = 0;
                else if (pv[1])     exp_g = 1;
            end
            check1("rnd_ready0", req0_ready, exp_g == 0);
            check1("rnd_ready1", req1_ready, exp_g == 1);
            e0 = 1'b0;
            e1 = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e0 = (exp_q[0].port == 0);
                e1 = (exp_q[0].port == 1);
            end
            check1("rnd_rsp0", rsp0_valid, e0);
            check1("rnd_rsp1", rsp1_valid, e1);
            if (e0 || e1) begin
                check("rnd_result", rsp_result, exp_q[0].res);
                check1("rnd_zero", rsp_zero, exp_q[0].zero);
                check1("rnd_err", rsp_err, 1'b0);
                void'(exp_q.pop_front());
            end
            acc[0] = (exp_g == 0);
            acc[1] = (exp_g == 1);
            if (exp_g >= 0) begin
                exp_t e;
                e.due  = cyc + 2;
                e.port = exp_g;
                e.res  = ref_alu(pc[exp_g], pa[exp_g], pb[exp_g]);
                e.zero = (e.res == 32'd0);
                exp_q.push_back(e);
                m_last = exp_g;
            end
            m_prev_acc = (exp_g >= 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. the datapath issue port and a multi-cycle helper such as an address or branch unit.
- Accepts an op and operands per requester over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU control/operand inputs from registers, captures the ALU result and zero flag, and returns them with a response pulse to the granted requester.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op pending.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_ctrl  in  CTRL_W  requester 0 ALU control code.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b: same as the requester 0 ports, for requester 1.
- alu_ctrl  out  CTRL_W  registered control code to the ALU.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_out  in  WIDTH  combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp0_valid, rsp1_valid  out  1  one-cycle response strobe per requester.
- rsp_result  out  WIDTH  captured result, shared by both requesters.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  illegal-op flag; always 0 unless the optional feature is compiled in.

Behaviour:
- Reset values: every output is 0; FSM = IDLE; last_grant = 1, so port 0 wins the first contention.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any reqN_valid, select a winner, assert its reqN_ready combinationally that cycle, latch its ctrl/a/b into alu_ctrl/alu_a/alu_b, record owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - ALU inputs are stable and no request is accepted.
  - Capture alu_out into rsp_result and alu_zero into rsp_zero, go to RESP.
- RESP:
  - rspN_valid = 1 for the owner for exactly one cycle.
  - In the same cycle, arbitration runs as in IDLE; if a request is accepted go to ISSUE (back-to-back), else go to IDLE.
- Latency: handshake in cycle T -> rspN_valid in cycle T+2.
- Throughput: one op every 2 cycles under continuous requests.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant updates on every accept.
- reqN_ready is never asserted without reqN_valid, and never to both ports in the same cycle.
- Requesters hold ctrl/a/b stable while valid and not ready.
- alu_ctrl/alu_a/alu_b hold their last latched values outside ISSUE.
- rsp_result/rsp_zero hold until the next capture.
- No response backpressure: rspN_valid is a pulse the requester must sample.
- Reset mid-operation: the in-flight op is discarded, no rsp strobe is issued, and all state returns to reset values the next cycle.
- The block performs no arithmetic; codes are passed through unmodified.

Optional Feature:
- Macro: ALU_SHARE_ARB_OPCHK_EN.
- Defined:
  - In the accept cycle, ctrl is checked against the legal set {1000 add, 1100 and, 1001 sub, 0100 or, 1011 sll, 1010 srl, 0010 sra, 0111 slt}.
  - An illegal code is still handshaken, but ISSUE leaves alu_* unchanged.
  - RESP then gives rsp_err = 1, rsp_result = 0, rsp_zero = 0.
  - rsp_err is valid only alongside rspN_valid.
- Undefined: no check is made; rsp_err is tied to 0.

Decomposition:
- Shared package alu_pkg:
  - CTRL_W and WIDTH defaults.
  - Localparams for the eight ALU control codes (ALU_ADD, ALU_AND, ALU_SUB, ALU_OR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT).
  - FSM state encoding.
  - The legal-op function used by the optional check.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Output: one-hot grant[1:0].
  - Purely combinational; last_grant is stored in the parent.

Test Plan:
- Single add on port 0: ctrl = 1000, a = b = 0x00425020 -> req0_ready at T, rsp0_valid at T+2, rsp_result = 0x0084A040, rsp_zero = 0, rsp1_valid stays 0.
- Subtract on port 1: ctrl = 1001, a = b = 0x00425020 -> rsp1_valid at T+2, rsp_result = 0, rsp_zero = 1.
- Contention after reset: both valid with port 0 or (0xFFFFFFE0 | 0x00425020) and port 1 sll (b = 0x0000000E):
  - port 0 granted first, rsp_result = 0xFFFFFFE0;
  - port 1 accepted in port 0's RESP cycle, rsp_result = 0x0000001C two cycles later;
  - a subsequent simultaneous request grants port 0.
- Back-to-back stream: port 0 holds valid for 4 ops -> accepts every 2 cycles, each response exactly 2 cycles after its accept, results in order.
- Reset asserted in ISSUE -> no rspN_valid pulse, all outputs 0 the following cycle, next contention grants port 0.
- With ALU_SHARE_ARB_OPCHK_EN, ctrl = 1111 -> handshake completes, alu_ctrl unchanged, rsp_err = 1 and rsp_result = 0 at T+2; without the macro, rsp_err stays 0.
